// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through, thresholds, flush and level.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr.
module sync_fifo_param #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_TH  = DEPTH - 1,
  parameter int unsigned AEMPTY_TH = 1,
  parameter int unsigned FWFT      = 0
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         rd_valid,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int unsigned AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_write;
  logic             do_read;
  logic             bypass;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == LW'(DEPTH));
  assign almost_empty = (count <= LW'(AEMPTY_TH));
  assign almost_full  = (count >= LW'(AFULL_TH));
  assign level        = count;

  // Bypass hands an incoming word straight to rd_data on an empty FIFO in registered mode.
  always_comb begin
    do_write = wr_en && (!full || rd_en);
    do_read  = rd_en && (!empty || (wr_en && (FWFT == 0)));
    bypass   = do_read && empty;
    push     = do_write && !bypass && !flush;
    pop      = do_read && !empty && !flush;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data  = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      logic             rv_q;

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else if (flush) begin
          rv_q <= 1'b0;
        end else begin
          rv_q <= do_read;
          if (bypass)       rd_q <= wr_data;
          else if (do_read) rd_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_q;
      assign rd_valid = rv_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  // Sticky error flags; a new event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) overflow <= 1'b1;
      else if (err_clr)            overflow <= 1'b0;
      if (rd_en && empty && !do_read) underflow <= 1'b1;
      else if (err_clr)               underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (depth 8 / depth 5 registered, depth 6 FWFT) share stimulus
// and are checked against a list-based model, a vector table and hand-written corner sequences.
module tb_sync_fifo_param;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        rd_en;

  logic [15:0] rdd [3];
  logic        rvl [3];
  logic        emp [3];
  logic        ful [3];
  logic        aem [3];
  logic        afl [3];
  logic [3:0]  lv0;
  logic [2:0]  lv1;
  logic [2:0]  lv2;
`ifdef SYNC_FIFO_ERR_EN
  logic        err_clr;
  logic        ovf [3];
  logic        unf [3];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sync_fifo_param #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u0 (
    .clk(clk), .rstN(rstN), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rdd[0]), .rd_valid(rvl[0]), .empty(emp[0]), .full(ful[0]),
    .almost_empty(aem[0]), .almost_full(afl[0]), .level(lv0)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(ovf[0]), .underflow(unf[0])
`endif
  );

  sync_fifo_param #(.WIDTH(16), .DEPTH(5), .FWFT(0)) u1 (
    .clk(clk), .rstN(rstN), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rdd[1]), .rd_valid(rvl[1]), .empty(emp[1]), .full(ful[1]),
    .almost_empty(aem[1]), .almost_full(afl[1]), .level(lv1)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(ovf[1]), .underflow(unf[1])
`endif
  );

  sync_fifo_param #(.WIDTH(16), .DEPTH(6), .AFULL_TH(4), .AEMPTY_TH(2), .FWFT(1)) u2 (
    .clk(clk), .rstN(rstN), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rdd[2]), .rd_valid(rvl[2]), .empty(emp[2]), .full(ful[2]),
    .almost_empty(aem[2]), .almost_full(afl[2]), .level(lv2)
`ifdef SYNC_FIFO_ERR_EN
    , .err_clr(err_clr), .overflow(ovf[2]), .underflow(unf[2])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep_of(input int i);
    case (i) 0: return 8; 1: return 5; default: return 6; endcase
  endfunction
  function automatic int af_of(input int i);
    case (i) 0: return 7; 1: return 4; default: return 4; endcase
  endfunction
  function automatic int ae_of(input int i);
    case (i) 0: return 1; 1: return 1; default: return 2; endcase
  endfunction
  function automatic bit fw_of(input int i);
    return (i == 2);
  endfunction
  function automatic int act_level(input int i);
    case (i) 0: return int'(lv0); 1: return int'(lv1); default: return int'(lv2); endcase
  endfunction

  // Model: contents held as an ordered list, head at index 0.
  logic [15:0] m   [3][8];
  int          n   [3];
  logic [15:0] mrd [3];
  bit          mrv [3];
  bit          mov [3];
  bit          mun [3];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      n[i] = 0; mrd[i] = '0; mrv[i] = 1'b0; mov[i] = 1'b0; mun[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int i, input bit w, input logic [15:0] wd,
                                     input bit r, input bit fl, input bit ec);
    int d;
    bit f, e, fu, dr;
    d  = dep_of(i);
    f  = fw_of(i);
    e  = (n[i] == 0);
    fu = (n[i] == d);
    dr = r && (!e || (w && !f));
    if (w && fu && !r) mov[i] = 1'b1; else if (ec) mov[i] = 1'b0;
    if (r && e && !dr) mun[i] = 1'b1; else if (ec) mun[i] = 1'b0;
    if (fl) begin
      n[i] = 0; mrv[i] = 1'b0;
      return;
    end
    if (!f && e && r && w) begin
      mrd[i] = wd; mrv[i] = 1'b1;
      return;
    end
    if (!f) mrv[i] = 1'b0;
    if (r && !e) begin
      if (!f) begin mrd[i] = m[i][0]; mrv[i] = 1'b1; end
      for (int k = 0; k < 7; k++) m[i][k] = m[i][k+1];
      n[i] = n[i] - 1;
    end
    if (w && (!fu || r)) begin
      m[i][n[i]] = wd;
      n[i] = n[i] + 1;
    end
  endfunction

  function automatic void cmp(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s u%0d: got 0x%0h expected 0x%0h at %0t", nm, i, act, exp, $time);
    end
  endfunction

  function automatic void check_dut(input int i);
    int xrd;
    bit xrv;
    if (fw_of(i)) begin
      xrv = (n[i] > 0);
      xrd = xrv ? int'(m[i][0]) : 0;
    end else begin
      xrv = mrv[i];
      xrd = int'(mrd[i]);
    end
    cmp("level", i, act_level(i), n[i]);
    cmp("empty", i, int'(emp[i]), int'(n[i] == 0));
    cmp("full", i, int'(ful[i]), int'(n[i] == dep_of(i)));
    cmp("almost_empty", i, int'(aem[i]), int'(n[i] <= ae_of(i)));
    cmp("almost_full", i, int'(afl[i]), int'(n[i] >= af_of(i)));
    cmp("rd_data", i, int'(rdd[i]), xrd);
    cmp("rd_valid", i, int'(rvl[i]), int'(xrv));
`ifdef SYNC_FIFO_ERR_EN
    cmp("overflow", i, int'(ovf[i]), int'(mov[i]));
    cmp("underflow", i, int'(unf[i]), int'(mun[i]));
`endif
  endfunction

  task automatic step(input bit w, input logic [15:0] wd, input bit r, input bit fl, input bit ec);
    wr_en = w; wr_data = wd; rd_en = r; flush = fl;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = ec;
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_step(i, w, wd, r, fl, ec);
    for (int i = 0; i < 3; i++) check_dut(i);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
  endtask

  typedef struct {
    bit          w;
    logic [15:0] wd;
    bit          r;
    int          lvl;
    bit          emp;
    bit          ful;
    bit          af;
    logic [15:0] rd;
    bit          rv;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Fill to full, drop one write, drain: expected values for the depth-8 instance.
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, 16'(k + 1), 1'b0, k + 1, 1'b0, (k == 7), (k + 1 >= 7), 16'h0000, 1'b0};
    tbl[8] = '{1'b1, 16'hDEAD, 1'b0, 8, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};
    for (int j = 1; j <= 8; j++)
      tbl[8 + j] = '{1'b0, 16'h0000, 1'b1, 8 - j, (j == 8), 1'b0, (8 - j >= 7), 16'(j), 1'b1};

    rstN = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
`ifdef SYNC_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_dut(i);
    @(negedge clk) rstN = 1'b1;

    for (int k = 0; k < 17; k++) begin
      step(tbl[k].w, tbl[k].wd, tbl[k].r, 1'b0, 1'b0);
      cmp("tbl_level", k, int'(lv0), tbl[k].lvl);
      cmp("tbl_empty", k, int'(emp[0]), int'(tbl[k].emp));
      cmp("tbl_full", k, int'(ful[0]), int'(tbl[k].ful));
      cmp("tbl_afull", k, int'(afl[0]), int'(tbl[k].af));
      cmp("tbl_rd_data", k, int'(rdd[0]), int'(tbl[k].rd));
      cmp("tbl_rd_valid", k, int'(rvl[0]), int'(tbl[k].rv));
    end

`ifdef SYNC_FIFO_ERR_EN
    cmp("ovf_sticky", 0, int'(ovf[0]), 1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cmp("ovf_hold", 0, int'(ovf[0]), 1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    cmp("ovf_clear", 0, int'(ovf[0]), 0);
`endif

    // Empty bypass in registered mode.
    step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    cmp("byp_rd", 0, int'(rdd[0]), 16'hBEEF);
    cmp("byp_rv", 0, int'(rvl[0]), 1);
    cmp("byp_level", 0, int'(lv0), 0);
    cmp("byp_empty", 0, int'(emp[0]), 1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cmp("byp_hold", 0, int'(rdd[0]), 16'hBEEF);
    cmp("byp_rv_drop", 0, int'(rvl[0]), 0);

    // Simultaneous read/write while full.
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) step(1'b1, 16'(k), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
    cmp("rw_full_rd", 0, int'(rdd[0]), 1);
    cmp("rw_full_level", 0, int'(lv0), 8);
    for (int k = 2; k <= 9; k++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      cmp("rw_full_seq", 0, int'(rdd[0]), k);
    end

    // Depth-5 wrap: three rounds of fill then drain.
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 0; k < 5; k++) begin
        step(1'b1, 16'(16'h0100 + rnd * 5 + k), 1'b0, 1'b0, 1'b0);
        cmp("d5_ae", 1, int'(aem[1]), int'(k + 1 <= 1));
        cmp("d5_af", 1, int'(afl[1]), int'(k + 1 >= 4));
      end
      for (int k = 0; k < 5; k++) begin
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cmp("d5_order", 1, int'(rdd[1]), 16'h0100 + rnd * 5 + k);
        cmp("d5_ae_rd", 1, int'(aem[1]), int'(4 - k <= 1));
      end
    end

    // FWFT: word visible one cycle after write, pop empties it.
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0);
    cmp("fwft_rd", 2, int'(rdd[2]), 16'h00A5);
    cmp("fwft_rv", 2, int'(rvl[2]), 1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cmp("fwft_empty", 2, int'(emp[2]), 1);

    // Flush outranks a same-cycle write.
    for (int k = 0; k < 5; k++) step(1'b1, 16'(16'h0200 + k), 1'b0, 1'b0, 1'b0);
    cmp("pre_flush_level", 0, int'(lv0), 5);
    step(1'b1, 16'h0777, 1'b0, 1'b1, 1'b0);
    cmp("flush_level", 0, int'(lv0), 0);
    cmp("flush_empty", 0, int'(emp[0]), 1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cmp("flush_nowrite", 0, int'(lv0), 0);

    // Asynchronous reset mid-stream, away from a clock edge.
    for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h0300 + k), 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cmp("pre_rst_rv", 0, int'(rvl[0]), 1);
    #2 rstN = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) check_dut(i);
    @(negedge clk) rstN = 1'b1;

    // Randomised traffic with shifting bias to visit full and empty.
    for (int s = 0; s < 3000; s++) begin
      int wb, rb;
      wb = ((s / 200) % 2 == 0) ? 70 : 30;
      rb = 100 - wb;
      step($urandom_range(0, 99) < wb, 16'($urandom), $urandom_range(0, 99) < rb,
           $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
